writeback: RTL

WRITEBACK -- requirements
Module: writeback

---
 rtl/instruction_data_pkg.sv | 31 +++
 rtl/writeback_load_align.sv | 33 +++
 rtl/writeback.sv | 95 +++++++++
 3 files changed

// File: rtl/instruction_data_pkg.sv
// Shared instruction/writeback types: source select, load size, FSM state
// and the load context captured while a load is outstanding.
package instruction_data;

  typedef enum logic {
    WB_SRC_PRE_WB = 1'b0,
    WB_SRC_LOAD   = 1'b1
  } wb_src_e;

  typedef enum logic [1:0] {
    LS_BYTE = 2'b00,
    LS_HALF = 2'b01,
    LS_WORD = 2'b10,
    LS_RSVD = 2'b11
  } load_size_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [4:0] rd;
    load_size_e size;
    logic       is_unsigned;
    logic [1:0] addr_low;
  } load_ctx_t;

  localparam int XLEN = 32;

endpackage

// File: rtl/writeback_load_align.sv
// Combinational load alignment: pick the addressed byte/half/word out of a
// little-endian memory word and sign- or zero-extend it to 32 bits.
module load_align
  import instruction_data::*;
(
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [1:0]      load_size,
  input  logic            load_unsigned,
  input  logic [1:0]      addr_low,
  output logic [XLEN-1:0] data_out
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_sh  = {addr_low, 3'b000};
  assign half_sh  = {addr_low[1], 4'b0000};
  assign byte_val = mem_rdata[byte_sh +: 8];
  assign half_val = mem_rdata[half_sh +: 16];

  always_comb begin
    data_out = mem_rdata;
    case (load_size)
      LS_BYTE: data_out = {{24{byte_val[7] & ~load_unsigned}}, byte_val};
      LS_HALF: data_out = {{16{half_val[15] & ~load_unsigned}}, half_val};
      // reserved size behaves as a word load
      default: data_out = mem_rdata;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: registers PRE_WB results directly, or parks a load in
// WAIT_MEM (stalling upstream) until memory returns data.
module writeback
  import instruction_data::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_enable,
  input  logic [XLEN-1:0] pre_wb,
  input  logic            wb_valid,
  input  logic            wb_src,
  input  logic [1:0]      load_size,
  input  logic            load_unsigned,
  input  logic [1:0]      addr_low,
  input  logic [4:0]      rd,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            stall
);

  wb_state_e       state_q, state_d;
  load_ctx_t       ld_q, ld_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [XLEN-1:0] load_data;

  load_align u_load_align (
    .mem_rdata     (mem_rdata),
    .load_size     (ld_q.size),
    .load_unsigned (ld_q.is_unsigned),
    .addr_low      (ld_q.addr_low),
    .data_out      (load_data)
  );

  always_comb begin
    state_d    = state_q;
    ld_d       = ld_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (clk_enable && wb_valid) begin
          if (wb_src_e'(wb_src) == WB_SRC_PRE_WB) begin
            rf_waddr_d = rd;
            rf_wdata_d = pre_wb;
            rf_we_d    = (rd != 5'd0);
          end else begin
            ld_d.rd          = rd;
            ld_d.size        = load_size_e'(load_size);
            ld_d.is_unsigned = load_unsigned;
            ld_d.addr_low    = addr_low;
            state_d          = ST_WAIT_MEM;
          end
        end
      end
      ST_WAIT_MEM: begin
        // memory response is taken even while the pipeline is frozen
        if (mem_rvalid) begin
          rf_waddr_d = ld_q.rd;
          rf_wdata_d = load_data;
          rf_we_d    = (ld_q.rd != 5'd0);
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ld_q       <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      ld_q       <= ld_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign stall    = (state_q == ST_WAIT_MEM);

endmodule
